// File: rtl/mult_sched.sv
// Two-channel round-robin scheduler in front of a shared Booth multiplier.
// Optional WAIT watchdog is enabled with `define MULT_SCHED_TIMEOUT_EN.
module mult_sched #(
  parameter int M_BITS         = 12,
  parameter int N_BITS         = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               req,
  input  logic [M_BITS-1:0]        mpd0,
  input  logic [M_BITS-1:0]        mpd1,
  input  logic [N_BITS-1:0]        mpr0,
  input  logic [N_BITS-1:0]        mpr1,
  output logic [1:0]               gnt,
  output logic [1:0]               done,
  output logic [M_BITS+N_BITS-1:0] prod,
  output logic                     err,
  output logic                     sched_busy,
  output logic                     mult_start,
  output logic [M_BITS-1:0]        mult_mpd,
  output logic [N_BITS-1:0]        mult_mpr,
  input  logic                     mult_busy,
  input  logic [M_BITS+N_BITS-1:0] mult_prod
);

  localparam int P_BITS = M_BITS + N_BITS;

  if (N_BITS > M_BITS || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mult_sched: invalid parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t state;
  logic   last;
  logic   cur;
  logic   pick;
  logic   tmo;

  // Tie goes to the channel not served last; a lone requester wins.
  assign pick = req[1] & (~req[0] | ~last);

  always_comb begin
    gnt = 2'b00;
    if (!rst && state == IDLE && req != 2'b00) begin
      gnt = pick ? 2'b10 : 2'b01;
    end
  end

`ifdef MULT_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt;

  assign tmo = (tcnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst || state != WAIT) begin
      tcnt <= '0;
    end else if (!tmo) begin
      tcnt <= tcnt + TW'(1);
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last       <= 1'b1;
      cur        <= 1'b0;
      mult_mpd   <= '0;
      mult_mpr   <= '0;
      mult_start <= 1'b0;
      sched_busy <= 1'b0;
      done       <= 2'b00;
      prod       <= '0;
`ifdef MULT_SCHED_TIMEOUT_EN
      err        <= 1'b0;
`endif
    end else begin
      mult_start <= 1'b0;
      done       <= 2'b00;
      prod       <= '0;
`ifdef MULT_SCHED_TIMEOUT_EN
      err        <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (gnt != 2'b00) begin
            cur        <= pick;
            mult_mpd   <= pick ? mpd1 : mpd0;
            mult_mpr   <= pick ? mpr1 : mpr0;
            mult_start <= 1'b1;
            sched_busy <= 1'b1;
            state      <= ISSUE;
          end
        end
        // Core busy is not meaningful until it has loaded the start.
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (!mult_busy) begin
            prod  <= mult_prod;
            done  <= cur ? 2'b10 : 2'b01;
            state <= DONE;
          end else if (tmo) begin
            prod  <= P_BITS'(0);
            done  <= cur ? 2'b10 : 2'b01;
`ifdef MULT_SCHED_TIMEOUT_EN
            err   <= 1'b1;
`endif
            state <= DONE;
          end
        end
        DONE: begin
          last       <= cur;
          sched_busy <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched with a behavioural Booth core model.
// Directed table, random jobs, mid-job reset, held-request round robin.
module tb_mult_sched;

  localparam int MB  = 12;
  localparam int NB  = 8;
  localparam int PB  = 20;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic [MB-1:0] mpd0, mpd1;
  logic [NB-1:0] mpr0, mpr1;
  logic [1:0]    gnt, done;
  logic [PB-1:0] prod;
  logic          err, sched_busy, mult_start;
  logic [MB-1:0] mult_mpd;
  logic [NB-1:0] mult_mpr;
  logic          mult_busy;
  logic [PB-1:0] mult_prod;

  mult_sched #(.M_BITS(MB), .N_BITS(NB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req(req),
    .mpd0(mpd0), .mpd1(mpd1), .mpr0(mpr0), .mpr1(mpr1),
    .gnt(gnt), .done(done), .prod(prod), .err(err),
    .sched_busy(sched_busy), .mult_start(mult_start),
    .mult_mpd(mult_mpd), .mult_mpr(mult_mpr),
    .mult_busy(mult_busy), .mult_prod(mult_prod)
  );

  always #5 clk = ~clk;

  function automatic logic [PB-1:0] mul(input logic [MB-1:0] a,
                                        input logic [NB-1:0] b);
    logic signed [PB-1:0] sa, sb;
    sa = {{NB{a[MB-1]}}, a};
    sb = {{MB{b[NB-1]}}, b};
    return sa * sb;
  endfunction

  // Booth core model: busy for 8 steps after start, product valid
  // only on the first idle cycle, then scrambled.
  int            core_cnt = 0;
  logic          core_fresh = 1'b0;
  logic [PB-1:0] core_p = '0;
  logic          force_busy = 1'b0;

  always @(posedge clk) begin
    if (mult_start) begin
      core_cnt   <= 8;
      core_p     <= mul(mult_mpd, mult_mpr);
      core_fresh <= 1'b0;
    end else if (core_cnt > 0) begin
      core_cnt   <= core_cnt - 1;
      core_fresh <= (core_cnt == 1);
    end else begin
      core_fresh <= 1'b0;
    end
  end

  assign mult_busy = (core_cnt != 0) | force_busy;
  assign mult_prod = core_fresh ? core_p : (core_p ^ 20'h5A5A5);

  int   errors = 0;
  int   checks = 0;
  logic rr_last;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model_pick(input logic [1:0] r);
    if (r == 2'b11) return ~rr_last;
    return r[1];
  endfunction

  task automatic wait_gnt(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 20; i++) begin
      #1;
      g = gnt;
      if (g != 2'b00) break;
      @(negedge clk);
    end
  endtask

  task automatic run_job(input logic [1:0] r,
                         input logic [MB-1:0] a0, input logic [NB-1:0] b0,
                         input logic [MB-1:0] a1, input logic [NB-1:0] b1,
                         input logic ech, input logic [PB-1:0] ep,
                         input int elat, input logic eerr,
                         input string tag);
    logic [1:0] g;
    int         n, starts;
    @(negedge clk);
    req = r; mpd0 = a0; mpr0 = b0; mpd1 = a1; mpr1 = b1;
    wait_gnt(g);
    check({tag, " gnt"}, 32'(g), ech ? 32'h2 : 32'h1);
    if (g == 2'b00) begin
      req = 2'b00;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req = 2'b00;
    n = 0;
    starts = 0;
    for (int i = 1; i <= 40; i++) begin
      if (mult_start) begin
        starts++;
        check({tag, " mpd"}, 32'(mult_mpd), 32'(ech ? a1 : a0));
        check({tag, " mpr"}, 32'(mult_mpr), 32'(ech ? b1 : b0));
      end
      if (done != 2'b00) begin
        n = i;
        check({tag, " done"}, 32'(done), ech ? 32'h2 : 32'h1);
        check({tag, " prod"}, 32'(prod), 32'(ep));
        check({tag, " err"}, 32'(err), 32'(eerr));
        break;
      end
      @(negedge clk);
    end
    check({tag, " latency"}, n, elat);
    check({tag, " starts"}, starts, 1);
    @(negedge clk);
    check({tag, " done clr"}, 32'(done), 0);
    check({tag, " prod clr"}, 32'(prod), 0);
    check({tag, " busy clr"}, 32'(sched_busy), 0);
    rr_last = ech;
  endtask

  typedef struct {
    logic [1:0]    req;
    logic [MB-1:0] mpd0;
    logic [NB-1:0] mpr0;
    logic [MB-1:0] mpd1;
    logic [NB-1:0] mpr1;
    logic          ech;
    logic [PB-1:0] eprod;
  } vec_t;

  vec_t          vt[6];
  int            gc[$], dc[$];
  logic [1:0]    gv[$], dv[$];
  logic [PB-1:0] dp[$];

  initial begin
    logic [1:0]    r, g;
    logic [MB-1:0] a0, a1;
    logic [NB-1:0] b0, b1;
    logic          ch;
    int            nd;

    vt[0] = '{2'b01, 12'h005, 8'h03, 12'h000, 8'h00, 1'b0, 20'h0000F};
    vt[1] = '{2'b10, 12'h000, 8'h00, 12'hFFD, 8'h04, 1'b1, 20'hFFFF4};
    vt[2] = '{2'b11, 12'h800, 8'h80, 12'h123, 8'h11, 1'b0, 20'h40000};
    vt[3] = '{2'b11, 12'h321, 8'h22, 12'h7FF, 8'h80, 1'b1, 20'hC0080};
    vt[4] = '{2'b01, 12'h7FF, 8'h7F, 12'h001, 8'h01, 1'b0, 20'h3F781};
    vt[5] = '{2'b10, 12'h00A, 8'h0A, 12'hFFF, 8'hFF, 1'b1, 20'h00001};

    rst = 1'b1; req = 2'b11;
    mpd0 = 12'hABC; mpr0 = 8'h5D; mpd1 = 12'h321; mpr1 = 8'hE7;
    @(negedge clk);
    @(negedge clk);
    check("rst gnt", 32'(gnt), 0);
    check("rst done", 32'(done), 0);
    check("rst prod", 32'(prod), 0);
    check("rst err", 32'(err), 0);
    check("rst busy", 32'(sched_busy), 0);
    check("rst start", 32'(mult_start), 0);
    check("rst mpd", 32'(mult_mpd), 0);
    check("rst mpr", 32'(mult_mpr), 0);
    rst = 1'b0; req = 2'b00;
    rr_last = 1'b1;

    for (int k = 0; k < 6; k++) begin
      run_job(vt[k].req, vt[k].mpd0, vt[k].mpr0, vt[k].mpd1, vt[k].mpr1,
              vt[k].ech, vt[k].eprod, 11, 1'b0, $sformatf("vec%0d", k));
    end

    for (int k = 0; k < 16; k++) begin
      r  = 2'($urandom_range(1, 3));
      a0 = MB'($urandom); b0 = NB'($urandom);
      a1 = MB'($urandom); b1 = NB'($urandom);
      ch = model_pick(r);
      run_job(r, a0, b0, a1, b1, ch,
              ch ? mul(a1, b1) : mul(a0, b0), 11, 1'b0,
              $sformatf("rnd%0d", k));
    end

    // Reset five cycles into a job must abandon it silently.
    @(negedge clk);
    req = 2'b01; mpd0 = 12'h0F0; mpr0 = 8'h0F;
    wait_gnt(g);
    check("abort gnt", 32'(g), 1);
    @(posedge clk);
    @(negedge clk);
    req = 2'b00;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(sched_busy), 0);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (done != 2'b00) nd++;
      @(negedge clk);
    end
    check("abort no done", nd, 0);
    rr_last = 1'b1;
    run_job(2'b01, 12'hF00, 8'h10, 12'h000, 8'h00, 1'b0,
            mul(12'hF00, 8'h10), 11, 1'b0, "after abort");

    // Both channels held from reset: ch0, ch1, ch0 at 12-cycle spacing.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 2'b11;
    mpd0 = 12'h0C3; mpr0 = 8'hF9; mpd1 = 12'hE41; mpr1 = 8'h35;
    for (int cyc = 0; cyc < 60 && dc.size() < 3; cyc++) begin
      #1;
      if (gnt != 2'b00) begin
        gc.push_back(cyc);
        gv.push_back(gnt);
      end else if (gc.size() == 3) begin
        req = 2'b00;
      end
      if (done != 2'b00) begin
        dc.push_back(cyc);
        dv.push_back(done);
        dp.push_back(prod);
      end
      @(negedge clk);
    end
    req = 2'b00;
    check("hold grants", gc.size(), 3);
    check("hold dones", dc.size(), 3);
    if (gc.size() == 3 && dc.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        ch = (k == 1);
        check($sformatf("hold gnt%0d", k), 32'(gv[k]), ch ? 2 : 1);
        check($sformatf("hold done%0d", k), 32'(dv[k]), ch ? 2 : 1);
        check($sformatf("hold lat%0d", k), dc[k] - gc[k], 11);
        check($sformatf("hold prod%0d", k), 32'(dp[k]),
              32'(ch ? mul(12'hE41, 8'h35) : mul(12'h0C3, 8'hF9)));
        if (k > 0) check($sformatf("hold gap%0d", k), dc[k] - dc[k-1], 12);
      end
    end
    repeat (3) @(negedge clk);
    rr_last = 1'b0;

`ifdef MULT_SCHED_TIMEOUT_EN
    force_busy = 1'b1;
    run_job(2'b01, 12'h011, 8'h22, 12'h000, 8'h00, 1'b0, 20'h0,
            TMO + 3, 1'b1, "timeout");
    force_busy = 1'b0;
    run_job(2'b10, 12'h000, 8'h00, 12'h055, 8'hC0, 1'b1,
            mul(12'h055, 8'hC0), 11, 1'b0, "post timeout");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
